pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: the unit is in reset while reset=0, regardless of clk.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- InstrD  in  20  decode-stage instruction bits [31:12]
- ALUFlags  in  4  {N,Z,C,V} from the execute-stage ALU
- FlushE  in  1  hazard-unit request to bubble the D->E control register
- RegSrcD  out  2  register-address mux selects
- ImmSrcD  out  2  extend-unit format
- ALUSrcE  out  1  SrcB select
- ALUControlE  out  3  ALU operation
- MemWriteM  out  1  data-memory write enable
- MemtoRegW  out  1  result-mux select
- RegWriteW  out  1  register-file write enable
- PCSrcW  out  1  PC-mux select
- RegWriteM  out  1  hazard-unit visibility
- MemtoRegE  out  1  hazard-unit visibility
- PCWrPendingF  out  1  PC write in flight in D, E or M

Function
REQ-003 Decode SHALL be combinational from InstrD: Op=[27:26], Funct=[25:20], Rd=[15:12], Cond=[31:28].
REQ-004 Op=00 (data processing) SHALL give:
- RegSrc=00, ImmSrc=00, ALUSrc=Funct[5].
- Cmd=Funct[4:1]: 0100 ADD->000, 0010 SUB->001, 0000 AND->010, 1100 ORR->011, 1010 CMP->001.
- RegW=1, except for CMP, where RegW=0 and the S bit is forced to 1.
REQ-005 Op=01 (memory) SHALL give:
- ImmSrc=01, ALUSrc=1, ALUControl=000.
- Funct[0]=1 (LDR): RegSrc=00, MemtoReg=1, RegW=1, MemW=0.
- Funct[0]=0 (STR): RegSrc=10, MemW=1, RegW=0.
REQ-006 Op=10 (branch) SHALL give RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=000, Branch=1, RegW=0.
REQ-007 Op=11 and any unlisted Cmd SHALL decode as a NOP: all write enables, Branch and FlagW equal 0.
REQ-008 FlagW SHALL be set as follows:
- FlagW[1] (updates N,Z) = S for data processing.
- FlagW[0] (updates C,V) = S AND the operation is ADD/SUB/CMP.
- FlagW SHALL be 0 for every non-DP instruction.
REQ-009 PCS SHALL equal Branch OR (RegW AND Rd=1111).
REQ-010 The D->E register SHALL capture ALUSrc, ALUControl, MemW, MemtoReg, RegW, PCS, FlagW and Cond on each rising edge.
REQ-011 When FlushE=1 at an edge, the D->E register SHALL load MemW=RegW=PCS=FlagW=0; the other fields are don't-care.
REQ-012 CondExE SHALL be computed from Cond and the flags register using the 15 standard ARM condition codes (EQ..AL); code 1111 SHALL evaluate false.
REQ-013 The flags register (4 bits) SHALL update each field group only when CondExE=1 and its FlagW bit=1, loading ALUFlags at the edge ending E.
REQ-014 The next instruction in E SHALL see the updated flags; no flag forwarding is required.
REQ-015 The E->M register SHALL capture MemW&CondExE, RegW&CondExE, PCS&CondExE and MemtoReg.
REQ-016 The M->W register SHALL capture RegW, PCS and MemtoReg.
REQ-017 Pipeline latencies SHALL be:
- ALUSrcE/ALUControlE: 1 edge after decode.
- MemWriteM: 2 edges after decode.
- RegWriteW/MemtoRegW/PCSrcW: 3 edges after decode.
REQ-018 PCWrPendingF SHALL equal PCS(D) OR PCS(E) OR PCS(M, after conditioning).
REQ-019 RegWriteM and MemtoRegE SHALL be driven directly from the pipeline registers.

Reset
REQ-020 While reset=0, all pipeline registers and the flags register SHALL hold 0, so every output driven from a register is 0 and CondExE is evaluated with flags 0000.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight instructions; no write enable may be asserted on the first edge after release.

Structure
REQ-022 A shared package ctrl_pkg SHALL hold Op encodings, the ALUControl encodings (ADD 000, SUB 001, AND 010, ORR 011), the Cmd codes and the condition-code constants.
REQ-023 The condition check and the flags register SHALL live in one sub-module named cond_unit.

Verification
REQ-024 Reset: reset=0 with arbitrary InstrD -> all registered outputs 0, flags 0000; after release, the first valid RegWriteW is 3 edges later.
REQ-025 ADD R1,R2,#5 (InstrD=0xE2821):
- RegSrcD=00, ImmSrcD=00.
- Next edge: ALUSrcE=1, ALUControlE=000.
- 3rd edge: RegWriteW=1, MemtoRegW=0.
REQ-026 SUBS R0,R0,#1 (0xE2500) with ALUFlags=0100 in E, followed by BNE (0x1AFFF) -> flags=0100, BNE CondExE=0, PCSrcW stays 0.
REQ-027 Repeat REQ-026 with ALUFlags=0000 -> PCSrcW=1 three edges after BNE decode, and PCWrPendingF=1 while the branch is in D, E and M.
REQ-028 LDR R3,[R4,#8] (0xE5943) -> ImmSrcD=01, ALUSrcE=1, MemWriteM=0, MemtoRegW=1, RegWriteW=1. STR (0xE5843) -> RegSrcD=10, MemWriteM=1, RegWriteW=0.
REQ-029 FlushE=1 coinciding with the ADD of REQ-025 -> MemWriteM, RegWriteW and PCSrcW remain 0 and the flags are unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: instruction-field
// encodings, ALU operation codes, data-processing command codes, ARM
// condition codes and the control bundles carried between pipeline stages.
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100
  } cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_code_e;

  // Control carried from decode into execute.
  typedef struct packed {
    logic       alu_src;
    alu_ctrl_e  alu_ctrl;
    logic       mem_w;
    logic       mem_to_reg;
    logic       reg_w;
    logic       pcs;
    logic [1:0] flag_w;
    logic [3:0] cond;
  } ctrl_e_t;

  // Control carried from execute into memory (writes already conditioned).
  typedef struct packed {
    logic mem_w;
    logic reg_w;
    logic pcs;
    logic mem_to_reg;
  } ctrl_m_t;

  // Control carried from memory into writeback.
  typedef struct packed {
    logic reg_w;
    logic pcs;
    logic mem_to_reg;
  } ctrl_w_t;

endpackage

// File: rtl/cond_unit.sv
// Condition check and NZCV flags register for the execute stage.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   cond         - condition field of the instruction in E
//   flag_w       - {update N/Z, update C/V} requests of the instruction in E
//   alu_flags    - {N,Z,C,V} produced by the ALU for the instruction in E
//   cond_ex      - the instruction in E is allowed to take effect
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w,
  input  logic [3:0] alu_flags,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (cond_code_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // N/Z and C/V are written independently; a failed condition blocks both.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && flag_w[1]) flags_d[3:2] = alu_flags[3:2];
    if (cond_ex && flag_w[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Control path of a five-stage ARM-subset pipeline: decodes the instruction
// in D and walks its control bits through E, M and W, squashing writes of
// instructions whose condition fails in E.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   InstrD          - instruction bits [31:12] in decode
//   ALUFlags        - {N,Z,C,V} from the execute-stage ALU
//   FlushE          - bubble the D->E control register
//   RegSrcD/ImmSrcD - decode-stage mux selects
//   ALUSrcE/ALUControlE/MemtoRegE - execute-stage control
//   MemWriteM/RegWriteM           - memory-stage control
//   MemtoRegW/RegWriteW/PCSrcW    - writeback-stage control
//   PCWrPendingF    - a PC write is in flight in D, E or M
module pipeline_control_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlags,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        MemWriteM,
  output logic        MemtoRegW,
  output logic        RegWriteW,
  output logic        PCSrcW,
  output logic        RegWriteM,
  output logic        MemtoRegE,
  output logic        PCWrPendingF
);

  op_e        op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic [3:0] cond_d;
  logic       s_d;
  logic       unused_rn;

  logic [1:0] dec_reg_src, dec_imm_src, dec_flag_w;
  logic       dec_alu_src, dec_mem_w, dec_mem_to_reg, dec_reg_w;
  logic       dec_branch, dec_pcs;
  alu_ctrl_e  dec_alu_ctrl;

  ctrl_e_t ctrl_e_d, ctrl_e_q;
  ctrl_m_t ctrl_m_d, ctrl_m_q;
  ctrl_w_t ctrl_w_d, ctrl_w_q;
  logic    cond_ex_e;

  // InstrD holds instruction bits [31:12], so bit k of the instruction is InstrD[k-12].
  assign cond_d    = InstrD[19:16];
  assign op_d      = op_e'(InstrD[15:14]);
  assign funct_d   = InstrD[13:8];
  assign rd_d      = InstrD[3:0];
  assign s_d       = funct_d[0];
  assign unused_rn = ^InstrD[7:4];

  always_comb begin
    dec_reg_src    = 2'b00;
    dec_imm_src    = 2'b00;
    dec_alu_src    = 1'b0;
    dec_alu_ctrl   = ALU_ADD;
    dec_mem_w      = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_w      = 1'b0;
    dec_branch     = 1'b0;
    dec_flag_w     = 2'b00;
    case (op_d)
      OP_DP: begin
        dec_alu_src = funct_d[5];
        case (cmd_e'(funct_d[4:1]))
          CMD_ADD: begin dec_alu_ctrl = ALU_ADD; dec_reg_w = 1'b1; dec_flag_w = {s_d, s_d};  end
          CMD_SUB: begin dec_alu_ctrl = ALU_SUB; dec_reg_w = 1'b1; dec_flag_w = {s_d, s_d};  end
          CMD_AND: begin dec_alu_ctrl = ALU_AND; dec_reg_w = 1'b1; dec_flag_w = {s_d, 1'b0}; end
          CMD_ORR: begin dec_alu_ctrl = ALU_ORR; dec_reg_w = 1'b1; dec_flag_w = {s_d, 1'b0}; end
          // Compare only exists for its flags: S is implied, no register write.
          CMD_CMP: begin dec_alu_ctrl = ALU_SUB; dec_flag_w = 2'b11; end
          default: ;
        endcase
      end
      OP_MEM: begin
        dec_imm_src = 2'b01;
        dec_alu_src = 1'b1;
        if (funct_d[0]) begin
          dec_mem_to_reg = 1'b1;
          dec_reg_w      = 1'b1;
        end else begin
          dec_reg_src = 2'b10;
          dec_mem_w   = 1'b1;
        end
      end
      OP_BR: begin
        dec_reg_src = 2'b01;
        dec_imm_src = 2'b10;
        dec_alu_src = 1'b1;
        dec_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Writing R15 redirects the PC just like a branch.
  assign dec_pcs = dec_branch | (dec_reg_w & (rd_d == 4'hF));

  // D -> E
  always_comb begin
    ctrl_e_d.alu_src    = dec_alu_src;
    ctrl_e_d.alu_ctrl   = dec_alu_ctrl;
    ctrl_e_d.mem_w      = dec_mem_w;
    ctrl_e_d.mem_to_reg = dec_mem_to_reg;
    ctrl_e_d.reg_w      = dec_reg_w;
    ctrl_e_d.pcs        = dec_pcs;
    ctrl_e_d.flag_w     = dec_flag_w;
    ctrl_e_d.cond       = cond_d;
    if (FlushE) begin
      ctrl_e_d.mem_w  = 1'b0;
      ctrl_e_d.reg_w  = 1'b0;
      ctrl_e_d.pcs    = 1'b0;
      ctrl_e_d.flag_w = 2'b00;
    end
  end

  cond_unit u_cond_unit (
    .clk       (clk),
    .reset     (reset),
    .cond      (ctrl_e_q.cond),
    .flag_w    (ctrl_e_q.flag_w),
    .alu_flags (ALUFlags),
    .cond_ex   (cond_ex_e)
  );

  // E -> M
  always_comb begin
    ctrl_m_d.mem_w      = ctrl_e_q.mem_w & cond_ex_e;
    ctrl_m_d.reg_w      = ctrl_e_q.reg_w & cond_ex_e;
    ctrl_m_d.pcs        = ctrl_e_q.pcs & cond_ex_e;
    ctrl_m_d.mem_to_reg = ctrl_e_q.mem_to_reg;
  end

  // M -> W
  always_comb begin
    ctrl_w_d.reg_w      = ctrl_m_q.reg_w;
    ctrl_w_d.pcs        = ctrl_m_q.pcs;
    ctrl_w_d.mem_to_reg = ctrl_m_q.mem_to_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  assign RegSrcD      = dec_reg_src;
  assign ImmSrcD      = dec_imm_src;
  assign ALUSrcE      = ctrl_e_q.alu_src;
  assign ALUControlE  = ctrl_e_q.alu_ctrl;
  assign MemtoRegE    = ctrl_e_q.mem_to_reg;
  assign MemWriteM    = ctrl_m_q.mem_w;
  assign RegWriteM    = ctrl_m_q.reg_w;
  assign MemtoRegW    = ctrl_w_q.mem_to_reg;
  assign RegWriteW    = ctrl_w_q.reg_w;
  assign PCSrcW       = ctrl_w_q.pcs;
  assign PCWrPendingF = dec_pcs | ctrl_e_q.pcs | ctrl_m_q.pcs;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: each issued cycle pushes the
// expected outputs of that cycle; a monitor pops and compares on the falling edge.
module tb_pipeline_control_unit;

  bit          clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD, ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        MemWriteM, MemtoRegW, RegWriteW, PCSrcW, RegWriteM, MemtoRegE, PCWrPendingF;

  pipeline_control_unit dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MemWriteM(MemWriteM), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] I_ADD  = 20'hE2821;
  localparam logic [19:0] I_SUBS = 20'hE2500;
  localparam logic [19:0] I_BNE  = 20'h1AFFF;
  localparam logic [19:0] I_BEQ  = 20'h0AFFF;
  localparam logic [19:0] I_LDR  = 20'hE5943;
  localparam logic [19:0] I_STR  = 20'hE5843;
  localparam logic [19:0] I_NOP  = 20'hEC000;
  localparam int MAXC = 4000;
  localparam int OFS  = 4;

  int total = 0;
  int bad   = 0;

  // Architectural meaning of one instruction.
  typedef struct {
    logic [1:0] reg_src, imm_src;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_w, mem_to_reg, reg_w, pcs, wr_nz, wr_cv;
    logic [3:0] cond;
    bit         sel_known, ctl_known;
  } dec_t;

  typedef struct {
    int         cyc;
    bit         sel_known, alu_src_known, alu_ctrl_known, mtr_e_known, mtr_w_known;
    logic [1:0] reg_src, imm_src;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mtr_e, memw_m, regw_m, regw_w, pcs_w, mtr_w, pcwr;
  } exp_t;

  exp_t exp_q[$];

  dec_t iss      [MAXC];
  bit   iss_fl   [MAXC];
  bit   iss_kill [MAXC];
  bit   res_memw [MAXC];
  bit   res_regw [MAXC];
  bit   res_pcs  [MAXC];
  bit   res_mtr  [MAXC];
  bit   res_mtrk [MAXC];
  logic [3:0] mflags;
  int   cyc;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req, input int c);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
    end
  endtask

  function automatic dec_t decode(input logic [19:0] ins);
    dec_t d;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] cmd;
    d = '{default: '0};
    op  = ins[15:14];
    fn  = ins[13:8];
    cmd = fn[4:1];
    d.cond = ins[19:16];
    d.sel_known = (op != 2'b11);
    if (op == 2'b00) begin
      d.alu_src = fn[5];
      d.ctl_known = 1'b1;
      if      (cmd == 4'b0100) begin d.alu_ctrl = 3'd0; d.reg_w = 1; d.wr_nz = fn[0]; d.wr_cv = fn[0]; end
      else if (cmd == 4'b0010) begin d.alu_ctrl = 3'd1; d.reg_w = 1; d.wr_nz = fn[0]; d.wr_cv = fn[0]; end
      else if (cmd == 4'b0000) begin d.alu_ctrl = 3'd2; d.reg_w = 1; d.wr_nz = fn[0]; end
      else if (cmd == 4'b1100) begin d.alu_ctrl = 3'd3; d.reg_w = 1; d.wr_nz = fn[0]; end
      else if (cmd == 4'b1010) begin d.alu_ctrl = 3'd1; d.wr_nz = 1; d.wr_cv = 1; end
      else d.ctl_known = 1'b0;
    end else if (op == 2'b01) begin
      d.imm_src = 2'b01; d.alu_src = 1; d.ctl_known = 1'b1;
      if (fn[0]) begin d.mem_to_reg = 1; d.reg_w = 1; end
      else begin d.reg_src = 2'b10; d.mem_w = 1; end
    end else if (op == 2'b10) begin
      d.reg_src = 2'b01; d.imm_src = 2'b10; d.alu_src = 1; d.ctl_known = 1'b1; d.pcs = 1;
    end
    if (d.reg_w && ins[3:0] == 4'hF) d.pcs = 1;
    return d;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs and record what the outputs must show during it.
  task automatic step(input logic [19:0] ins, input bit fl, input logic [3:0] af, input logic rv);
    exp_t e;
    dec_t cur, ed;
    int   k;
    bit   ok, live;
    @(posedge clk); #1;
    InstrD = ins; FlushE = fl; ALUFlags = af; reset = rv;
    k = cyc + OFS;
    cur = decode(ins);
    iss[k] = cur; iss_fl[k] = fl; iss_kill[k] = !rv;
    e = '{default: '0};
    e.cyc = cyc;
    e.sel_known = cur.sel_known; e.reg_src = cur.reg_src; e.imm_src = cur.imm_src;
    if (!rv) begin
      mflags = 4'b0000;
      iss_kill[k-1] = 1'b1;
      for (int j = 1; j <= 3; j++) begin
        res_memw[k-j] = 0; res_regw[k-j] = 0; res_pcs[k-j] = 0; res_mtr[k-j] = 0; res_mtrk[k-j] = 1;
      end
      e.alu_src_known = 1; e.alu_ctrl_known = 1; e.mtr_e_known = 1; e.mtr_w_known = 1;
      e.pcwr = cur.pcs;
    end else begin
      ed   = iss[k-1];
      live = !iss_kill[k-1] && !iss_fl[k-1];
      ok   = cond_ok(ed.cond, mflags);
      res_memw[k-1] = live && ok && ed.mem_w;
      res_regw[k-1] = live && ok && ed.reg_w;
      res_pcs[k-1]  = live && ok && ed.pcs;
      res_mtr[k-1]  = iss_kill[k-1] ? 1'b0 : ed.mem_to_reg;
      res_mtrk[k-1] = iss_kill[k-1] || !iss_fl[k-1];
      if (live && ok && ed.wr_nz) mflags[3:2] = af[3:2];
      if (live && ok && ed.wr_cv) mflags[1:0] = af[1:0];
      if (iss_kill[k-1]) begin
        e.alu_src_known = 1; e.alu_ctrl_known = 1; e.mtr_e_known = 1;
      end else if (!iss_fl[k-1]) begin
        e.alu_src_known = ed.sel_known; e.alu_src = ed.alu_src;
        e.alu_ctrl_known = ed.ctl_known; e.alu_ctrl = ed.alu_ctrl;
        e.mtr_e_known = 1; e.mtr_e = ed.mem_to_reg;
      end
      e.memw_m = res_memw[k-2]; e.regw_m = res_regw[k-2];
      e.regw_w = res_regw[k-3]; e.pcs_w = res_pcs[k-3];
      e.mtr_w = res_mtr[k-3]; e.mtr_w_known = res_mtrk[k-3];
      e.pcwr = cur.pcs | (live & ed.pcs) | res_pcs[k-2];
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic spot(input string nm, input logic [3:0] act, input logic [3:0] req);
    chk(nm, act, req, cyc - 1);
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] cnd, rn, rd, cmd;
    logic [1:0] op;
    logic [5:0] fn;
    cnd = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    op  = 2'($urandom);
    fn  = 6'($urandom);
    if (op == 2'b00 && $urandom_range(0, 5) != 0) begin
      case ($urandom_range(0, 4))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        default: cmd = 4'b1010;
      endcase
      fn[4:1] = cmd;
    end
    rn = 4'($urandom);
    rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    return {cnd, op, fn, rn, rd};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.sel_known) begin
          chk("RegSrcD", 4'(RegSrcD), 4'(e.reg_src), e.cyc);
          chk("ImmSrcD", 4'(ImmSrcD), 4'(e.imm_src), e.cyc);
        end
        if (e.alu_src_known)  chk("ALUSrcE", 4'(ALUSrcE), 4'(e.alu_src), e.cyc);
        if (e.alu_ctrl_known) chk("ALUControlE", 4'(ALUControlE), 4'(e.alu_ctrl), e.cyc);
        if (e.mtr_e_known)    chk("MemtoRegE", 4'(MemtoRegE), 4'(e.mtr_e), e.cyc);
        chk("MemWriteM", 4'(MemWriteM), 4'(e.memw_m), e.cyc);
        chk("RegWriteM", 4'(RegWriteM), 4'(e.regw_m), e.cyc);
        chk("RegWriteW", 4'(RegWriteW), 4'(e.regw_w), e.cyc);
        chk("PCSrcW", 4'(PCSrcW), 4'(e.pcs_w), e.cyc);
        if (e.mtr_w_known)    chk("MemtoRegW", 4'(MemtoRegW), 4'(e.mtr_w), e.cyc);
        chk("PCWrPendingF", 4'(PCWrPendingF), 4'(e.pcwr), e.cyc);
      end
    end
  end

  // Stimulus
  initial begin
    logic rv;
    for (int i = 0; i < MAXC; i++) begin
      iss[i] = '{default: '0}; iss_fl[i] = 0; iss_kill[i] = 1;
      res_memw[i] = 0; res_regw[i] = 0; res_pcs[i] = 0; res_mtr[i] = 0; res_mtrk[i] = 1;
    end
    mflags = 4'b0000; cyc = 0;
    reset = 1'b0; InstrD = '0; ALUFlags = '0; FlushE = 1'b0;

    // Reset with arbitrary instructions present
    for (int i = 0; i < 3; i++) step(20'($urandom), 1'b0, 4'($urandom), 1'b0);
    @(negedge clk);
    spot("rst_RegWriteW", 4'(RegWriteW), 4'h0);
    spot("rst_MemWriteM", 4'(MemWriteM), 4'h0);
    spot("rst_ALUSrcE", 4'(ALUSrcE), 4'h0);

    // ADD R1,R2,#5 right after release
    step(I_ADD, 0, 4'h0, 1);
    @(negedge clk); spot("add_RegSrcD", 4'(RegSrcD), 4'h0); spot("add_ImmSrcD", 4'(ImmSrcD), 4'h0);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("add_ALUSrcE", 4'(ALUSrcE), 4'h1); spot("add_ALUControlE", 4'(ALUControlE), 4'h0);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("add_RegWriteW_early", 4'(RegWriteW), 4'h0);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("add_RegWriteW", 4'(RegWriteW), 4'h1); spot("add_MemtoRegW", 4'(MemtoRegW), 4'h0);

    // SUBS sets Z, BNE must not be taken
    step(I_SUBS, 0, 4'h0, 1);
    step(I_BNE, 0, 4'b0100, 1);
    step(I_NOP, 0, 4'($urandom), 1);
    step(I_NOP, 0, 4'($urandom), 1);
    step(I_NOP, 0, 4'($urandom), 1);
    @(negedge clk); spot("bne_nt_PCSrcW", 4'(PCSrcW), 4'h0);

    // SUBS clears Z, BNE taken
    step(I_SUBS, 0, 4'h0, 1);
    step(I_BNE, 0, 4'b0000, 1);
    @(negedge clk); spot("bne_pend_D", 4'(PCWrPendingF), 4'h1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("bne_pend_E", 4'(PCWrPendingF), 4'h1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("bne_pend_M", 4'(PCWrPendingF), 4'h1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("bne_t_PCSrcW", 4'(PCSrcW), 4'h1);

    // LDR then STR
    step(I_LDR, 0, 4'h0, 1);
    @(negedge clk); spot("ldr_ImmSrcD", 4'(ImmSrcD), 4'h1);
    step(I_STR, 0, 4'h0, 1);
    @(negedge clk); spot("ldr_ALUSrcE", 4'(ALUSrcE), 4'h1); spot("str_RegSrcD", 4'(RegSrcD), 4'h2);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("ldr_MemWriteM", 4'(MemWriteM), 4'h0);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk);
    spot("ldr_MemtoRegW", 4'(MemtoRegW), 4'h1); spot("ldr_RegWriteW", 4'(RegWriteW), 4'h1);
    spot("str_MemWriteM", 4'(MemWriteM), 4'h1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("str_RegWriteW", 4'(RegWriteW), 4'h0);

    // Flushed ADD leaves no writes
    step(I_ADD, 1, 4'h0, 1);
    step(I_NOP, 0, 4'h0, 1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("flush_MemWriteM", 4'(MemWriteM), 4'h0); spot("flush_RegWriteM", 4'(RegWriteM), 4'h0);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("flush_RegWriteW", 4'(RegWriteW), 4'h0); spot("flush_PCSrcW", 4'(PCSrcW), 4'h0);

    // Flushed SUBS must not set Z, so BEQ stays not taken
    step(I_SUBS, 1, 4'h0, 1);
    step(I_BEQ, 0, 4'b0100, 1);
    step(I_NOP, 0, 4'h0, 1);
    step(I_NOP, 0, 4'h0, 1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk); spot("flush_flags_PCSrcW", 4'(PCSrcW), 4'h0);

    // Reset in the middle of traffic
    step(I_ADD, 0, 4'h0, 1);
    step(I_STR, 0, 4'h0, 1);
    step(I_BNE, 0, 4'h0, 0);
    step(I_NOP, 0, 4'h0, 0);
    step(I_ADD, 0, 4'h0, 1);
    step(I_NOP, 0, 4'h0, 1);
    @(negedge clk);
    spot("rel_MemWriteM", 4'(MemWriteM), 4'h0); spot("rel_RegWriteM", 4'(RegWriteM), 4'h0);
    spot("rel_RegWriteW", 4'(RegWriteW), 4'h0); spot("rel_PCSrcW", 4'(PCSrcW), 4'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 199) != 0);
      step(rand_instr(), ($urandom_range(0, 7) == 0), 4'($urandom), rv);
    end
    for (int i = 0; i < 4; i++) step(I_NOP, 0, 4'h0, 1);

    @(negedge clk); #1;
    chk("scoreboard_drained", 4'(exp_q.size() != 0), 4'h0, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
